cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the N_CDB common-data-bus broadcast slots among the ALU and MUL functional-unit result ports.
- Sits between the functional units and the CDB that feeds the ROB commit-flag update, and the register-file/reservation-station wakeup.
- Selects up to N_CDB ready results per cycle with rotating round-robin priority, handshakes each requester, and registers the winners onto the bus.

Parameters:
- N_REQ, 4: number of result requesters, ALU ports first, then MUL ports.
- N_CDB, 2: broadcast slots per cycle, 1 <= N_CDB <= N_REQ.
- ROB_DEPTH, 8: ROB entries; ROB_IDX_W = $clog2(ROB_DEPTH).
- STARVE_LIMIT, 7: starvation threshold in cycles, used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; discards outstanding grants
- req_valid  in  [N_REQ]  requester i holds a completed result
- req_ready  out  [N_REQ]  requester i granted this cycle (combinational)
- req_rob_id  in  [N_REQ][ROB_IDX_W]  ROB index of result
- req_rd  in  [N_REQ][5]  destination architectural register
- req_value  in  [N_REQ][32]  result value
- cdb_valid  out  [N_CDB]  slot k broadcasting (registered)
- cdb_rob_id  out  [N_CDB][ROB_IDX_W]  broadcast ROB index
- cdb_rd  out  [N_CDB][5]  broadcast destination register
- cdb_value  out  [N_CDB][32]  broadcast value
- cdb_src  out  [N_CDB][$clog2(N_REQ)]  granted requester index

Behaviour:
- Reset: cdb_valid=0, cdb_rob_id/cdb_rd/cdb_value/cdb_src=0, rr_ptr=0, starvation counters=0. req_ready is 0 while rst=1.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i] in the same cycle. The requester holds valid and payload stable until it sees ready. req_ready never depends on anything but req_valid, rr_ptr, counters, flush, and rst.
- Grant: scan indices rr_ptr, rr_ptr+1, ... mod N_REQ. The first N_CDB valid requesters win in scan order; the k-th winner maps to slot k. At most N_CDB req_ready bits are set.
- Latency: 1 cycle. Winners are registered at the posedge into cdb_* with cdb_valid[k]=1. Unused slots get cdb_valid[k]=0 and payload 0.
- Pointer update: rr_ptr <= (index of last winner + 1) mod N_REQ. It is unchanged when there are no winners. Wrap-around from N_REQ-1 to 0 is required.
- Full contention (all N_REQ valid, N_REQ > N_CDB): every requester is granted within ceil(N_REQ/N_CDB) cycles.
- flush=1: req_ready=0 for all requesters, next cdb_valid=0, rr_ptr=0, counters cleared. Requesters drop their results themselves.
- Reset mid-operation: registered slots are lost; the state above takes effect the next cycle.
- No state machine beyond rr_ptr, the output registers, and the optional counters.

Optional Feature:
- CDB_STARVE_GUARD_EN defined:
  - Per-requester counter of width $clog2(STARVE_LIMIT+1).
  - Increments while valid and not granted; clears on grant or when valid is low; saturates at STARVE_LIMIT.
  - A requester at STARVE_LIMIT is forced into slot 0 ahead of the rotation. If several are starved, the lowest index wins.
  - Remaining slots fill by normal rotation, skipping the forced winner.
  - rr_ptr updates from the last rotation winner only.
- Undefined: no counters; pure round-robin.

Decomposition:
- Shared package rv32i_types: add cdb_entry_t {rob_id, rd, value} and constants N_CDB and CDB_STARVE_LIMIT. N_ALU and N_MUL already live there; N_REQ = N_ALU + N_MUL.
- One sub-module, rr_pick_n: combinational rotating-priority picker returning up to N grant indices from a request vector and a start pointer. Reused for the issue arbiters.

Test Plan:
- Reset with all req_valid=1 → req_ready=0000 during rst. After release: grants to 0,1, cdb_src={0,1} the next cycle, rr_ptr=2.
- Continuous req_valid=1111, N_CDB=2 → grant sets {0,1},{2,3},{0,1}. cdb_valid=11 each cycle, cdb_value matches each source's payload.
- req_valid=1000 only (requester 3) with rr_ptr=3 → slot0=3, slot1 invalid, rr_ptr wraps to 0.
- flush asserted with req_valid=0110 → req_ready=0000, next cdb_valid=00, rr_ptr=0.
- Requester holds valid across a 0-ready cycle → payload observed unchanged; exactly one broadcast of rob_id 5 after ready.
- CDB_STARVE_GUARD_EN, STARVE_LIMIT=2, N_CDB=1: inject requester 3 while 0,1,2 contend in a skewed pattern → requester 3 is granted in slot 0 within 3 cycles of asserting valid.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared pipeline types and sizing constants for the RV32I core.
// CDB broadcast entry and arbiter sizing live alongside the FU counts.
package rv32i_types;

  localparam int N_ALU            = 2;
  localparam int N_MUL            = 2;
  localparam int N_REQ            = N_ALU + N_MUL;
  localparam int N_CDB            = 2;
  localparam int ROB_DEPTH        = 8;
  localparam int ROB_IDX_W        = $clog2(ROB_DEPTH);
  localparam int CDB_STARVE_LIMIT = 7;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_id;
    logic [4:0]           rd;
    logic [31:0]          value;
  } cdb_entry_t;

endpackage

// File: rtl/rr_pick_n.sv
// Combinational rotating-priority picker: scans req from start upward (mod N_REQ)
// and returns the first N_PICK set indices in scan order.
module rr_pick_n #(
  parameter  int N_REQ  = 4,
  parameter  int N_PICK = 2,
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]             req,
  input  logic [IDX_W-1:0]             start,
  output logic [N_PICK-1:0]            gnt_valid,
  output logic [N_PICK-1:0][IDX_W-1:0] gnt_idx
);

  localparam int SUM_W = IDX_W + 1;

  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] idx;
    int               cnt;
    gnt_valid = '0;
    gnt_idx   = '0;
    cnt       = 0;
    for (int o = 0; o < N_REQ; o++) begin
      // start is always < N_REQ, so one conditional subtract wraps the index
      sum = {1'b0, start} + SUM_W'(o);
      if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
      idx = sum[IDX_W-1:0];
      if (req[idx] && (cnt < N_PICK)) begin
        for (int k = 0; k < N_PICK; k++) begin
          if (cnt == k) begin
            gnt_valid[k] = 1'b1;
            gnt_idx[k]   = idx;
          end
        end
        cnt = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares N_CDB common-data-bus slots among FU result ports with round-robin priority.
// Optional starvation guard enabled by defining CDB_STARVE_GUARD_EN.
// Handshake: a result moves when req_valid[i] && req_ready[i]; the requester holds
// valid and payload stable until ready, and ready depends only on valid, rr_ptr,
// starvation counters, flush and rst (never on the payload).
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int N_REQ     = rv32i_types::N_REQ,
  parameter int N_CDB     = rv32i_types::N_CDB,
  parameter int ROB_DEPTH = rv32i_types::ROB_DEPTH
`ifdef CDB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = CDB_STARVE_LIMIT
`endif
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [N_REQ-1:0]                      req_valid,
  output logic [N_REQ-1:0]                      req_ready,
  input  logic [N_REQ-1:0][$clog2(ROB_DEPTH)-1:0] req_rob_id,
  input  logic [N_REQ-1:0][4:0]                 req_rd,
  input  logic [N_REQ-1:0][31:0]                req_value,
  output logic [N_CDB-1:0]                      cdb_valid,
  output logic [N_CDB-1:0][$clog2(ROB_DEPTH)-1:0] cdb_rob_id,
  output logic [N_CDB-1:0][4:0]                 cdb_rd,
  output logic [N_CDB-1:0][31:0]                cdb_value,
  output logic [N_CDB-1:0][((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] cdb_src
);

  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [SRC_W-1:0]            rr_ptr;
  logic [N_REQ-1:0]            rot_req;
  logic [N_CDB-1:0]            pick_valid;
  logic [N_CDB-1:0][SRC_W-1:0] pick_idx;
  logic                        force_valid;
  logic [SRC_W-1:0]            force_idx;
  logic [N_CDB-1:0]            slot_valid;
  logic [N_CDB-1:0][SRC_W-1:0] slot_src;
  logic                        rot_any;
  logic [SRC_W-1:0]            rot_last;
  logic [N_REQ-1:0]            grant_mask;

`ifdef CDB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [N_REQ-1:0][CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst || flush || !req_valid[i] || req_ready[i]) starve_cnt[i] <= '0;
      else if (starve_cnt[i] != CNT_W'(STARVE_LIMIT))   starve_cnt[i] <= starve_cnt[i] + 1'b1;
    end
  end

  // Lowest starved index wins the forced slot; it is hidden from the rotation
  always_comb begin
    force_valid = 1'b0;
    force_idx   = '0;
    rot_req     = req_valid;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (starve_cnt[i] == CNT_W'(STARVE_LIMIT))) begin
        force_valid = 1'b1;
        force_idx   = SRC_W'(i);
      end
    end
    if (force_valid) rot_req[force_idx] = 1'b0;
  end
`else
  assign force_valid = 1'b0;
  assign force_idx   = '0;
  assign rot_req     = req_valid;
`endif

  rr_pick_n #(
    .N_REQ  (N_REQ),
    .N_PICK (N_CDB)
  ) u_pick (
    .req       (rot_req),
    .start     (rr_ptr),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  always_comb begin
    slot_valid = '0;
    slot_src   = '0;
    rot_any    = 1'b0;
    rot_last   = '0;
    if (force_valid) begin
      slot_valid[0] = 1'b1;
      slot_src[0]   = force_idx;
      for (int k = 1; k < N_CDB; k++) begin
        slot_valid[k] = pick_valid[k-1];
        slot_src[k]   = pick_idx[k-1];
        if (pick_valid[k-1]) begin
          rot_any  = 1'b1;
          rot_last = pick_idx[k-1];
        end
      end
    end else begin
      for (int k = 0; k < N_CDB; k++) begin
        slot_valid[k] = pick_valid[k];
        slot_src[k]   = pick_idx[k];
        if (pick_valid[k]) begin
          rot_any  = 1'b1;
          rot_last = pick_idx[k];
        end
      end
    end
  end

  always_comb begin
    grant_mask = '0;
    for (int k = 0; k < N_CDB; k++) begin
      if (slot_valid[k]) grant_mask[slot_src[k]] = 1'b1;
    end
    req_ready = (rst || flush) ? '0 : grant_mask;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr     <= '0;
      cdb_valid  <= '0;
      cdb_rob_id <= '0;
      cdb_rd     <= '0;
      cdb_value  <= '0;
      cdb_src    <= '0;
    end else begin
      if (rot_any) rr_ptr <= (rot_last == SRC_W'(N_REQ - 1)) ? '0 : rot_last + 1'b1;
      for (int k = 0; k < N_CDB; k++) begin
        cdb_valid[k] <= slot_valid[k];
        if (slot_valid[k]) begin
          cdb_rob_id[k] <= req_rob_id[slot_src[k]];
          cdb_rd[k]     <= req_rd[slot_src[k]];
          cdb_value[k]  <= req_value[slot_src[k]];
          cdb_src[k]    <= slot_src[k];
        end else begin
          cdb_rob_id[k] <= '0;
          cdb_rd[k]     <= '0;
          cdb_value[k]  <= '0;
          cdb_src[k]    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter in its default build (N_REQ=4, N_CDB=2).
module tb_cdb_arbiter;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [3:0]           req_valid;
  logic [3:0]           req_ready;
  logic [3:0][2:0]      req_rob_id;
  logic [3:0][4:0]      req_rd;
  logic [3:0][31:0]     req_value;
  logic [1:0]           cdb_valid;
  logic [1:0][2:0]      cdb_rob_id;
  logic [1:0][4:0]      cdb_rd;
  logic [1:0][31:0]     cdb_value;
  logic [1:0][1:0]      cdb_src;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [2:0]  p_rob[4];
  logic [4:0]  p_rd[4];
  logic [31:0] p_val[4];

  typedef struct {
    logic [3:0] valid;
    logic       flush;
    logic [3:0] exp_ready;
    logic [1:0] exp_cv;
    logic [1:0] exp_s0;
    logic [1:0] exp_s1;
  } vec_t;

  vec_t vecs[13];

  cdb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rob_id (req_rob_id),
    .req_rd     (req_rd),
    .req_value  (req_value),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_rd     (cdb_rd),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: expected broadcast values go through exp_q
  task automatic check_cdb(input string tag, input logic [1:0] cv, input logic [1:0] s0,
                           input logic [1:0] s1);
    logic [1:0]  s[2];
    logic [31:0] e;
    s[0] = s0;
    s[1] = s1;
    chk({tag, " cdb_valid"}, 64'(cdb_valid), 64'(cv));
    for (int k = 0; k < 2; k++) begin
      if (cv[k]) begin
        exp_q.push_back(p_val[s[k]]);
        chk($sformatf("%s slot%0d src", tag, k), 64'(cdb_src[k]), 64'(s[k]));
        chk($sformatf("%s slot%0d rob", tag, k), 64'(cdb_rob_id[k]), 64'(p_rob[s[k]]));
        chk($sformatf("%s slot%0d rd", tag, k), 64'(cdb_rd[k]), 64'(p_rd[s[k]]));
        e = exp_q.pop_front();
        chk($sformatf("%s slot%0d value", tag, k), 64'(cdb_value[k]), 64'(e));
      end else begin
        chk($sformatf("%s slot%0d idle payload", tag, k),
            64'({cdb_src[k], cdb_rob_id[k], cdb_rd[k], cdb_value[k]}), 64'd0);
      end
    end
  endtask

  // driver
  task automatic drive(input logic [3:0] v, input logic f);
    req_valid = v;
    flush     = f;
  endtask

  initial begin
    int n5;
    p_rob[0] = 3'd0; p_rob[1] = 3'd1; p_rob[2] = 3'd2; p_rob[3] = 3'd5;
    for (int i = 0; i < 4; i++) begin
      p_rd[i]       = 5'(i + 10);
      p_val[i]      = 32'hC0DE_0000 + 32'(i) * 32'h111;
      req_rob_id[i] = p_rob[i];
      req_rd[i]     = p_rd[i];
      req_value[i]  = p_val[i];
    end

    //          valid    flush exp_ready cv     s0     s1
    vecs[0]  = '{4'b1111, 1'b0, 4'b0011, 2'b11, 2'd0, 2'd1};  // ptr 0 -> 2
    vecs[1]  = '{4'b1111, 1'b0, 4'b1100, 2'b11, 2'd2, 2'd3};  // ptr 2 -> 0
    vecs[2]  = '{4'b1111, 1'b0, 4'b0011, 2'b11, 2'd0, 2'd1};  // ptr 0 -> 2
    vecs[3]  = '{4'b0100, 1'b0, 4'b0100, 2'b01, 2'd2, 2'd0};  // ptr 2 -> 3
    vecs[4]  = '{4'b1000, 1'b0, 4'b1000, 2'b01, 2'd3, 2'd0};  // ptr 3 wraps -> 0
    vecs[5]  = '{4'b0110, 1'b0, 4'b0110, 2'b11, 2'd1, 2'd2};  // ptr 0 -> 3
    vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0};  // ptr stays 3
    vecs[7]  = '{4'b1011, 1'b0, 4'b1001, 2'b11, 2'd3, 2'd0};  // ptr 3 -> 1
    vecs[8]  = '{4'b0110, 1'b1, 4'b0000, 2'b00, 2'd0, 2'd0};  // flush: ptr -> 0
    vecs[9]  = '{4'b1111, 1'b0, 4'b0011, 2'b11, 2'd0, 2'd1};  // ptr 0 -> 2
    vecs[10] = '{4'b0101, 1'b0, 4'b0101, 2'b11, 2'd2, 2'd0};  // ptr 2 -> 1
    vecs[11] = '{4'b1010, 1'b0, 4'b1010, 2'b11, 2'd1, 2'd3};  // ptr 1 -> 0
    vecs[12] = '{4'b0001, 1'b0, 4'b0001, 2'b01, 2'd0, 2'd0};  // ptr 0 -> 1

    rst = 1'b1;
    drive(4'b1111, 1'b0);
    #1 chk("reset ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clk);
    chk("reset ready held", 64'(req_ready), 64'd0);
    check_cdb("reset", 2'b00, 2'd0, 2'd0);
    rst = 1'b0;

    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].valid, vecs[v].flush);
      #1 chk($sformatf("vec%0d ready", v), 64'(req_ready), 64'(vecs[v].exp_ready));
      @(negedge clk);
      check_cdb($sformatf("vec%0d", v), vecs[v].exp_cv, vecs[v].exp_s0, vecs[v].exp_s1);
    end

    // requester 3 (rob 5) waits one cycle without ready, then broadcasts once
    n5 = 0;
    drive(4'b1110, 1'b0);
    #1 chk("hold ready", 64'(req_ready), 64'b0110);
    @(negedge clk);
    check_cdb("hold wait", 2'b11, 2'd1, 2'd2);
    for (int k = 0; k < 2; k++) if (cdb_valid[k] && cdb_rob_id[k] == 3'd5) n5++;
    drive(4'b1000, 1'b0);
    #1 chk("hold grant ready", 64'(req_ready), 64'b1000);
    @(negedge clk);
    check_cdb("hold bcast", 2'b01, 2'd3, 2'd0);
    for (int k = 0; k < 2; k++) if (cdb_valid[k] && cdb_rob_id[k] == 3'd5) n5++;
    drive(4'b0000, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) if (cdb_valid[k] && cdb_rob_id[k] == 3'd5) n5++;
    chk("hold idle cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rob5 broadcast count", 64'(n5), 64'd1);

    // reset in mid-operation drops the registered slots and rewinds the pointer
    drive(4'b1111, 1'b0);
    #1 chk("midrst pre ready", 64'(req_ready), 64'b0011);
    @(negedge clk);
    check_cdb("midrst pre", 2'b11, 2'd0, 2'd1);
    rst = 1'b1;
    #1 chk("midrst ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check_cdb("midrst", 2'b00, 2'd0, 2'd0);
    rst = 1'b0;
    #1 chk("midrst post ready", 64'(req_ready), 64'b0011);
    @(negedge clk);
    check_cdb("midrst post", 2'b11, 2'd0, 2'd1);
    drive(4'b0000, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
